cgra_test_sequencer: RTL and testbench
======================================

CGRA_TEST_SEQUENCER -- requirements
Module: cgra_test_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, stimulus/response width (1..32); CFG_AW, default 8, config-memory index width; MAX_LAT, default 8, maximum DUT latency in cycles.
REQ-002 clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 reset_in  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle pulse that begins a test run; ignored unless state is IDLE or DONE.
REQ-005 cfg_count  input  CFG_AW+1  number of config words to stream (0..2^CFG_AW).
REQ-006 cfg_rd_addr  output  CFG_AW  index into external config memory.
REQ-007 cfg_rd_data  input  64  {addr[63:32], data[31:0]} from that memory, valid one cycle after cfg_rd_addr.
REQ-008 config_addr_out / config_data_out  output  32 each  config bus driven into the CGRA top.
REQ-009 mode  input  2  stimulus mode: 0 up-counter, 1 LFSR, 2 constant, 3 reserved (treated as 0).
REQ-010 const_val  input  DATA_W  stimulus value in mode 2.
REQ-011 shift  input  4  expected response = stimulus << shift.
REQ-012 lat  input  log2(MAX_LAT+1)  DUT latency; values above MAX_LAT clamp to MAX_LAT.
REQ-013 run_cycles  input  32  number of RUN cycles.
REQ-014 stim_out  output  DATA_W  stimulus driven to the CGRA pads.
REQ-015 dut_in  input  DATA_W  response sampled from the CGRA pads.
REQ-016 busy, done, pass  output  1 each  status; err_count  output  16  mismatch count; first_err  output  32  RUN index of first mismatch.

Function
REQ-017 The FSM SHALL have states IDLE, CONFIG, RUN, DONE; transitions: IDLE/DONE -start-> CONFIG (or RUN if cfg_count==0); CONFIG -last word emitted-> RUN; RUN -run_cycles elapsed-> DONE.
REQ-018 In CONFIG, cfg_rd_addr SHALL step 0..cfg_count-1, one index per cycle, and word i SHALL appear on config_addr_out/config_data_out exactly 2 cycles after cfg_rd_addr==i, one word per cycle, with no gaps.
REQ-019 Outside valid config words, config_addr_out and config_data_out SHALL be 0.
REQ-020 RUN cycle index t SHALL run 0..run_cycles-1; run_cycles==0 SHALL go directly to DONE with pass=1.
REQ-021 stim_out at RUN t SHALL be: mode 0 t mod 2^DATA_W (wraps); mode 1 low DATA_W bits of a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 0xACE1 at t=0, zero-extended when DATA_W>16); mode 2 const_val; stim_out SHALL hold 0 outside RUN.
REQ-022 Expected(t) SHALL be (stim(t-lat) << shift) truncated to DATA_W; comparison of dut_in SHALL occur in RUN cycles with t>=lat only.
REQ-023 Each mismatch SHALL increment err_count, saturating at 0xFFFF; first_err SHALL latch t of the first mismatch and be 0xFFFFFFFF if none.
REQ-024 busy SHALL be 1 in CONFIG and RUN; done SHALL be 1 only in DONE; pass SHALL equal done && err_count==0.
REQ-025 A start in DONE SHALL clear err_count, first_err, LFSR and t before CONFIG.
REQ-026 mode, const_val, shift, lat, run_cycles, cfg_count SHALL be captured on accepted start and held constant for the run.

Reset
REQ-027 reset_in SHALL force IDLE, all outputs 0 except first_err=0xFFFFFFFF, clear delay line and counters, and abort any run mid-CONFIG or mid-RUN in the same cycle.

Structure
REQ-028 Package cgra_test_pkg SHALL hold the state enum, the mode enum, LFSR seed and tap constants.
REQ-029 The latency delay line SHALL be a sub-module cgra_tb_delay_line (DATA_W x MAX_LAT+1 taps, selectable tap, synchronous clear).

Verification
REQ-030 cfg_count=3, memory {0x10:0xA,0x11:0xB,0x12:0xC} -> three consecutive config pairs 2 cycles after first read, then 0/0, then RUN.
REQ-031 mode 0, shift 1, lat 0, run_cycles 10000, dut_in=2*stim_out -> done, pass=1, err_count=0.
REQ-032 mode 1, lat 3, DUT model delaying 3 cycles -> pass=1; same with model delay 2 -> err_count=run_cycles-3.
REQ-033 mode 0, DATA_W=16, run_cycles 70000, dut_in stuck at 0 from t=5 -> first_err=5, err_count saturates 0xFFFF.
REQ-034 reset_in asserted mid-RUN then start -> run restarts at t=0, config re-streamed, counters cleared.
REQ-035 start pulsed during CONFIG and RUN -> ignored; cfg_count=0 -> no config words, RUN immediately.

Source files
------------

// File: rtl/cgra_test_pkg.sv
// Shared types and constants for the CGRA test sequencer.
package cgra_test_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONFIG = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_RSVD  = 2'd3
    } stim_mode_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Register shifts right; taps 16,14,13,11 land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {^(cur & LFSR_TAP_MASK), cur[15:1]};
    endfunction

endpackage

// File: rtl/cgra_tb_delay_line.sv
// Stimulus delay line: tap k is the input delayed by k cycles, tap 0 is the
// input itself. Synchronous clear empties every stage.
module cgra_tb_delay_line #(
    parameter int DATA_W  = 16,
    parameter int MAX_LAT = 8,
    localparam int SEL_W  = $clog2(MAX_LAT + 1)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] pipe [1:MAX_LAT];

    // Shift one stage per cycle, cleared on demand.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int k = 1; k <= MAX_LAT; k++) pipe[k] <= '0;
        end else begin
            pipe[1] <= din;
            for (int k = 2; k <= MAX_LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    // Tap select; sel is pre-clamped by the caller.
    always_comb begin
        dout = din;
        for (int k = 1; k <= MAX_LAT; k++) begin
            if (sel == SEL_W'(k)) dout = pipe[k];
        end
    end

endmodule

// File: rtl/cgra_test_sequencer.sv
// CGRA test sequencer: streams config words into the array, drives a
// stimulus pattern, and checks the delayed/shifted response.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start after reset
// S_CONFIG | reading config memory and replaying words on the config bus
// S_RUN    | driving stimulus, comparing response once t >= lat
// S_DONE   | results held; start launches a fresh run
module cgra_test_sequencer
    import cgra_test_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CFG_AW  = 8,
    parameter int MAX_LAT = 8,
    localparam int LAT_W  = $clog2(MAX_LAT + 1)
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              start,
    input  logic [CFG_AW:0]   cfg_count,
    output logic [CFG_AW-1:0] cfg_rd_addr,
    input  logic [63:0]       cfg_rd_data,
    output logic [31:0]       config_addr_out,
    output logic [31:0]       config_data_out,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] const_val,
    input  logic [3:0]        shift,
    input  logic [LAT_W-1:0]  lat,
    input  logic [31:0]       run_cycles,
    output logic [DATA_W-1:0] stim_out,
    input  logic [DATA_W-1:0] dut_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [31:0]       first_err
);

    // Config cycle counter must reach cfg_count+1 (read latency plus output stage).
    localparam int CYC_W = CFG_AW + 2;
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);

    seq_state_e        state;
    stim_mode_e        mode_r;
    logic [DATA_W-1:0] const_r;
    logic [3:0]        shift_r;
    logic [LAT_W-1:0]  lat_r;
    logic [31:0]       run_r;
    logic [CYC_W-1:0]  cfg_cnt_r;
    logic [CYC_W-1:0]  cfg_cyc;
    logic [CYC_W-1:0]  cfg_cyc_nxt;
    logic              cfg_rd_vld;
    logic [31:0]       t_r;
    logic [31:0]       t_nxt;
    logic [15:0]       lfsr_r;
    logic [15:0]       lfsr_nxt;
    logic              start_ok;
    logic [DATA_W-1:0] tap_val;
    logic [DATA_W-1:0] expected;

    function automatic logic [DATA_W-1:0] stim_of(input stim_mode_e m,
                                                   input logic [31:0] t,
                                                   input logic [15:0] lfsr,
                                                   input logic [DATA_W-1:0] cval);
        logic [DATA_W-1:0] v;
        case (m)
            MODE_LFSR:  v = DATA_W'(lfsr);
            MODE_CONST: v = cval;
            default:    v = t[DATA_W-1:0];
        endcase
        return v;
    endfunction

    assign start_ok    = start && (state == S_IDLE || state == S_DONE);
    assign expected    = tap_val << shift_r;
    assign cfg_cyc_nxt = cfg_cyc + CYC_W'(1);
    assign t_nxt       = t_r + 32'd1;
    assign lfsr_nxt    = lfsr_step(lfsr_r);
    assign pass        = done && (err_count == 16'd0);

    cgra_tb_delay_line #(
        .DATA_W  (DATA_W),
        .MAX_LAT (MAX_LAT)
    ) u_delay (
        .clk  (clk_in),
        .clr  (reset_in || start_ok),
        .din  (stim_out),
        .sel  (lat_r),
        .dout (tap_val)
    );

    // Sequencer FSM with registered outputs and run bookkeeping.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state           <= S_IDLE;
            mode_r          <= MODE_COUNT;
            const_r         <= '0;
            shift_r         <= '0;
            lat_r           <= '0;
            run_r           <= '0;
            cfg_cnt_r       <= '0;
            cfg_cyc         <= '0;
            cfg_rd_vld      <= 1'b0;
            cfg_rd_addr     <= '0;
            config_addr_out <= '0;
            config_data_out <= '0;
            t_r             <= '0;
            lfsr_r          <= LFSR_SEED;
            stim_out        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_count       <= '0;
            first_err       <= '1;
        end else begin
            cfg_rd_vld      <= 1'b0;
            config_addr_out <= cfg_rd_vld ? cfg_rd_data[63:32] : 32'd0;
            config_data_out <= cfg_rd_vld ? cfg_rd_data[31:0]  : 32'd0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_r      <= stim_mode_e'(mode);
                        const_r     <= const_val;
                        shift_r     <= shift;
                        lat_r       <= (lat > LAT_MAX) ? LAT_MAX : lat;
                        run_r       <= run_cycles;
                        cfg_cnt_r   <= CYC_W'(cfg_count);
                        cfg_cyc     <= '0;
                        cfg_rd_addr <= '0;
                        t_r         <= '0;
                        lfsr_r      <= LFSR_SEED;
                        err_count   <= '0;
                        first_err   <= '1;
                        done        <= 1'b0;
                        if (cfg_count != '0) begin
                            state <= S_CONFIG;
                            busy  <= 1'b1;
                        end else if (run_cycles != 32'd0) begin
                            state    <= S_RUN;
                            busy     <= 1'b1;
                            stim_out <= stim_of(stim_mode_e'(mode), 32'd0, LFSR_SEED, const_val);
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_CONFIG: begin
                    cfg_rd_vld  <= (cfg_cyc < cfg_cnt_r);
                    cfg_cyc     <= cfg_cyc_nxt;
                    cfg_rd_addr <= (cfg_cyc_nxt < cfg_cnt_r) ? cfg_cyc_nxt[CFG_AW-1:0] : '0;
                    // Last word is on the bus during cycle cfg_count+1.
                    if (cfg_cyc == cfg_cnt_r + CYC_W'(1)) begin
                        if (run_r != 32'd0) begin
                            state    <= S_RUN;
                            stim_out <= stim_of(mode_r, 32'd0, LFSR_SEED, const_r);
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (t_r >= 32'(lat_r) && dut_in != expected) begin
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        if (first_err == 32'hFFFF_FFFF) first_err <= t_r;
                    end
                    if (t_r == run_r - 32'd1) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        stim_out <= '0;
                    end else begin
                        t_r      <= t_nxt;
                        lfsr_r   <= lfsr_nxt;
                        stim_out <= stim_of(mode_r, t_nxt, lfsr_nxt, const_r);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_test_sequencer.sv
// Directed bench for cgra_test_sequencer: config streaming, stimulus modes,
// latency/shift checking, saturation, restart and reset abort.
module tb_cgra_test_sequencer;

    localparam int DATA_W  = 16;
    localparam int CFG_AW  = 8;
    localparam int MAX_LAT = 8;
    localparam int LAT_W   = 4;

    logic              clk_in = 1'b0;
    logic              reset_in = 1'b1;
    logic              start = 1'b0;
    logic [CFG_AW:0]   cfg_count = '0;
    logic [CFG_AW-1:0] cfg_rd_addr;
    logic [63:0]       cfg_rd_data = '0;
    logic [31:0]       config_addr_out;
    logic [31:0]       config_data_out;
    logic [1:0]        mode = '0;
    logic [DATA_W-1:0] const_val = '0;
    logic [3:0]        shift = '0;
    logic [LAT_W-1:0]  lat = '0;
    logic [31:0]       run_cycles = '0;
    logic [DATA_W-1:0] stim_out;
    logic [DATA_W-1:0] dut_in;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       err_count;
    logic [31:0]       first_err;

    int n_tests = 0;
    int n_fail  = 0;
    int dsel     = 0;
    int tb_shift = 0;
    int tb_dly   = 1;
    logic [DATA_W-1:0] dq [1:8];
    logic stuck = 1'b0;

    always #5 clk_in = ~clk_in;

    cgra_test_sequencer #(
        .DATA_W  (DATA_W),
        .CFG_AW  (CFG_AW),
        .MAX_LAT (MAX_LAT)
    ) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .start           (start),
        .cfg_count       (cfg_count),
        .cfg_rd_addr     (cfg_rd_addr),
        .cfg_rd_data     (cfg_rd_data),
        .config_addr_out (config_addr_out),
        .config_data_out (config_data_out),
        .mode            (mode),
        .const_val       (const_val),
        .shift           (shift),
        .lat             (lat),
        .run_cycles      (run_cycles),
        .stim_out        (stim_out),
        .dut_in          (dut_in),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err       (first_err)
    );

    // Config memory: word i = {0x10+i, 0xA+i}, one-cycle read latency.
    always @(posedge clk_in)
        cfg_rd_data <= {32'h10 + 32'(cfg_rd_addr), 32'hA + 32'(cfg_rd_addr)};

    // Response models: delayed copies of stim_out and stuck-at-0 latch.
    always @(posedge clk_in) begin
        dq[1] <= stim_out;
        for (int i = 2; i <= 8; i++) dq[i] <= dq[i-1];
        if (dsel == 3 && busy && stim_out == 16'd5) stuck <= 1'b1;
    end

    always_comb begin
        case (dsel)
            1:       dut_in = dq[tb_dly];
            3:       dut_in = (stuck || stim_out == 16'd5) ? '0 : stim_out;
            default: dut_in = DATA_W'(stim_out << tb_shift);
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        assert (obs === want)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
        end
    endtask

    task automatic setup(input int cnt, input int md, input int cv,
                         input int sh, input int lt, input int rc);
        cfg_count  = cnt[CFG_AW:0];
        mode       = md[1:0];
        const_val  = cv[DATA_W-1:0];
        shift      = sh[3:0];
        lat        = lt[LAT_W-1:0];
        run_cycles = rc;
    endtask

    // Returns at the negedge of the first cycle after start is accepted.
    task automatic pulse_start();
        @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_in);
        reset_in = 1'b0;
        @(negedge clk_in);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_first", first_err, 32'hFFFF_FFFF);
        chk("rst_stim", 32'(stim_out), 32'd0);
        chk("rst_cfga", config_addr_out, 32'd0);
        chk("rst_rdad", 32'(cfg_rd_addr), 32'd0);

        // Config streaming, 3 words, then constant-mode run
        dsel = 0; tb_shift = 0;
        setup(3, 2, 'h1234, 0, 0, 4);
        pulse_start();
        chk("cfg_k0_rdad", 32'(cfg_rd_addr), 32'd0);
        chk("cfg_k0_busy", 32'(busy), 32'd1);
        @(negedge clk_in);
        chk("cfg_k1_rdad", 32'(cfg_rd_addr), 32'd1);
        chk("cfg_k1_a", config_addr_out, 32'd0);
        @(negedge clk_in);
        chk("cfg_k2_rdad", 32'(cfg_rd_addr), 32'd2);
        chk("cfg_k2_a", config_addr_out, 32'h10);
        chk("cfg_k2_d", config_data_out, 32'hA);
        @(negedge clk_in);
        chk("cfg_k3_a", config_addr_out, 32'h11);
        chk("cfg_k3_d", config_data_out, 32'hB);
        @(negedge clk_in);
        chk("cfg_k4_a", config_addr_out, 32'h12);
        chk("cfg_k4_d", config_data_out, 32'hC);
        chk("cfg_k4_stim", 32'(stim_out), 32'd0);
        @(negedge clk_in);
        chk("cfg_k5_a", config_addr_out, 32'd0);
        chk("cfg_k5_d", config_data_out, 32'd0);
        chk("cfg_k5_stim", 32'(stim_out), 32'h1234);
        wait_done("cfg_run_done", 20);
        chk("cfg_run_pass", 32'(pass), 32'd1);
        chk("cfg_run_busy", 32'(busy), 32'd0);

        // Up-counter, shift 1, 10000 cycles
        tb_shift = 1;
        setup(0, 0, 0, 1, 0, 10000);
        pulse_start();
        chk("cnt_t0", 32'(stim_out), 32'd0);
        @(negedge clk_in);
        chk("cnt_t1", 32'(stim_out), 32'd1);
        @(negedge clk_in);
        chk("cnt_t2", 32'(stim_out), 32'd2);
        wait_done("cnt_done", 10010);
        chk("cnt_pass", 32'(pass), 32'd1);
        chk("cnt_err", 32'(err_count), 32'd0);
        chk("cnt_first", first_err, 32'hFFFF_FFFF);

        // LFSR, lat 3, response delayed 3
        dsel = 1; tb_dly = 3; tb_shift = 0;
        setup(0, 1, 0, 0, 3, 100);
        pulse_start();
        chk("lfsr_t0", 32'(stim_out), 32'hACE1);
        @(negedge clk_in);
        chk("lfsr_t1", 32'(stim_out), 32'h5670);
        @(negedge clk_in);
        chk("lfsr_t2", 32'(stim_out), 32'hAB38);
        @(negedge clk_in);
        chk("lfsr_t3", 32'(stim_out), 32'h559C);
        wait_done("lfsr3_done", 200);
        chk("lfsr3_pass", 32'(pass), 32'd1);
        chk("lfsr3_err", 32'(err_count), 32'd0);

        // Same, response delayed only 2
        tb_dly = 2;
        pulse_start();
        wait_done("lfsr2_done", 200);
        chk("lfsr2_err", 32'(err_count), 32'd97);
        chk("lfsr2_first", first_err, 32'd3);
        chk("lfsr2_pass", 32'(pass), 32'd0);

        // run_cycles 0 from DONE: clears results, straight to DONE
        setup(0, 0, 0, 0, 0, 0);
        pulse_start();
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_pass", 32'(pass), 32'd1);
        chk("zero_err", 32'(err_count), 32'd0);
        chk("zero_first", first_err, 32'hFFFF_FFFF);
        chk("zero_busy", 32'(busy), 32'd0);

        // Latency above MAX_LAT clamps to MAX_LAT
        tb_dly = 8;
        setup(0, 1, 0, 0, 15, 40);
        pulse_start();
        wait_done("clamp_done", 100);
        chk("clamp_pass", 32'(pass), 32'd1);

        // Reserved mode behaves as up-counter
        dsel = 0; tb_shift = 2;
        setup(0, 3, 'h7777, 2, 0, 5);
        pulse_start();
        chk("m3_t0", 32'(stim_out), 32'd0);
        @(negedge clk_in);
        chk("m3_t1", 32'(stim_out), 32'd1);
        @(negedge clk_in);
        chk("m3_t2", 32'(stim_out), 32'd2);
        wait_done("m3_done", 20);
        chk("m3_pass", 32'(pass), 32'd1);

        // start during CONFIG and RUN is ignored; inputs captured at start
        tb_shift = 0;
        setup(3, 2, 'h00F0, 0, 0, 20);
        pulse_start();
        @(negedge clk_in);
        start = 1'b1;
        cfg_count = 9'd5;
        @(negedge clk_in);
        start = 1'b0;
        chk("ign_cfg_rdad", 32'(cfg_rd_addr), 32'd2);
        repeat (2) @(negedge clk_in);
        chk("ign_k4_a", config_addr_out, 32'h12);
        chk("ign_k4_d", config_data_out, 32'hC);
        @(negedge clk_in);
        chk("ign_k5_a", config_addr_out, 32'd0);
        chk("ign_k5_stim", 32'(stim_out), 32'h00F0);
        repeat (5) @(negedge clk_in);
        start = 1'b1;
        const_val = 16'h0F0F;
        shift = 4'd3;
        @(negedge clk_in);
        start = 1'b0;
        chk("ign_run_stim", 32'(stim_out), 32'h00F0);
        repeat (13) @(negedge clk_in);
        chk("ign_k24_done", 32'(done), 32'd0);
        @(negedge clk_in);
        chk("ign_k25_done", 32'(done), 32'd1);
        chk("ign_pass", 32'(pass), 32'd1);

        // Reset mid-RUN, then restart
        tb_shift = 1;
        setup(3, 0, 0, 0, 0, 50);
        pulse_start();
        repeat (15) @(negedge clk_in);
        chk("mid_err", 32'(err_count), 32'd9);
        chk("mid_first", first_err, 32'd1);
        reset_in = 1'b1;
        @(negedge clk_in);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_stim", 32'(stim_out), 32'd0);
        chk("abort_err", 32'(err_count), 32'd0);
        chk("abort_first", first_err, 32'hFFFF_FFFF);
        reset_in = 1'b0;
        tb_shift = 0;
        pulse_start();
        chk("re_k0_rdad", 32'(cfg_rd_addr), 32'd0);
        repeat (2) @(negedge clk_in);
        chk("re_k2_a", config_addr_out, 32'h10);
        repeat (3) @(negedge clk_in);
        chk("re_k5_stim", 32'(stim_out), 32'd0);
        @(negedge clk_in);
        chk("re_k6_stim", 32'(stim_out), 32'd1);
        wait_done("re_done", 100);
        chk("re_pass", 32'(pass), 32'd1);

        // Stuck-at-0 from t=5 over 70000 cycles: saturation
        dsel = 3;
        setup(0, 0, 0, 0, 0, 70000);
        pulse_start();
        wait_done("sat_done", 70100);
        chk("sat_first", first_err, 32'd5);
        chk("sat_err", 32'(err_count), 32'hFFFF);
        chk("sat_pass", 32'(pass), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
